jt12_timers_ab: RTL and testbench
=================================

// Module: jt12_timers_ab
// PURPOSE
//  FM timer A/B block; consumes the prescaled FM clock enable (clk_en) from the clock divider.
//  Derives the FM sample tick (one tick per SLOTS clk_en pulses).
//  Timer A counts every sample; timer B counts every B_DIV samples.
//  Produces status flags, an active-low IRQ and an overflow strobe for the register/interface stage.
// PARAMETERS
//  SLOTS   24  clk_en pulses per FM sample; legal range 2..31.
//  B_DIV   16  samples per timer B tick; power of two, 2..16.
// PORTS
//  clk           in   1   system clock; all logic on posedge.
//  rst_n         in   1   asynchronous, active-low reset.
//  clk_en        in   1   prescaled FM enable from the clock divider; one-cycle pulses.
//  value_A       in   10  timer A load value.
//  value_B       in   8   timer B load value.
//  load_A        in   1   level; 1 = timer A running.
//  load_B        in   1   level; 1 = timer B running.
//  flagen_A      in   1   allow timer A overflow to set flag_A.
//  flagen_B      in   1   allow timer B overflow to set flag_B.
//  clr_flag_A    in   1   one-cycle pulse; clears flag_A.
//  clr_flag_B    in   1   one-cycle pulse; clears flag_B.
//  flag_A        out  1   timer A status flag.
//  flag_B        out  1   timer B status flag.
//  overflow_A    out  1   one-cycle strobe on each timer A overflow.
//  irq_n         out  1   low while flag_A or flag_B is set.
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Counters cnt_A, cnt_B, slot_cnt and bdiv_cnt = 0.
//   - flag_A = flag_B = overflow_A = 0; irq_n = 1.
//   - Reset released mid-count restarts every counter from 0.
//  Sample tick:
//   - slot_cnt increments on each clk_en and wraps SLOTS-1 -> 0.
//   - tick = clk_en & (slot_cnt == SLOTS-1); combinational, same cycle.
//   - No tick occurs without clk_en; clk_en held high gives a tick every SLOTS cycles.
//  Timer A:
//   - load_A 0->1 (edge detected on clk, independent of clk_en): cnt_A <= value_A on that cycle.
//   - load_A=0: cnt_A holds its value and raises no overflow.
//   - On a tick with load_A=1 and cnt_A == 1023: cnt_A <= value_A, overflow_A = 1 on the next cycle.
//   - On a tick with load_A=1 otherwise: cnt_A + 1.
//   - Period = (1024 - value_A) samples; value_A = 1023 gives an overflow on every tick.
//   - A value_A change while running takes effect only at the next reload.
//  Timer B:
//   - bdiv_cnt increments on each tick and wraps at B_DIV-1; btick = tick & (bdiv_cnt == B_DIV-1).
//   - bdiv_cnt runs free regardless of load_B.
//   - Same load, hold and reload rules as timer A, 8-bit, wrapping at 255.
//   - Period = (256 - value_B) * B_DIV samples, with up to B_DIV-1 samples of phase jitter from the free-running divider.
//  Flags:
//   - flag_X is set one cycle after an overflow if flagen_X = 1; overflow_A fires regardless of flagen_A.
//   - Set and clr_flag_X in the same cycle: set wins.
//   - Flags stay set while the timer is stopped; only clr_flag_X or reset clears them.
//   - irq_n = ~(flag_A | flag_B); registered, so it follows the flags with no extra delay.
//  Simultaneous events:
//   - A load edge in the same cycle as an overflow: the reload to value is taken, and the overflow still strobes and flags.
// CONFIGURATION
//  Macro TIMER_CSM_EN:
//   - Defined: adds output port csm_keyon (1 bit).
//     It pulses for exactly SLOTS clk_en periods, starting at the cycle overflow_A asserts, when input csm_mode (1 bit) = 1.
//     A retrigger during the pulse restarts its length.
//   - Undefined: ports csm_keyon and csm_mode are absent and no extra logic is built.
// TESTING
//  1 rst_n=0 mid-count, then release -> all outputs at reset values; first tick SLOTS clk_en later.
//  2 clk_en=1, SLOTS=24, value_A=1020, load_A rises, flagen_A=1
//    -> overflow_A at the 4th tick (cycle 96 after load); flag_A=1 and irq_n=0 the following cycle.
//  3 value_B=254, load_B=1, flagen_B=0 -> no flag_B, irq_n stays 1.
//    Then flagen_B=1 -> flag_B set 32 samples after the next overflow.
//  4 clr_flag_A in the same cycle as an overflow_A flag set -> flag_A=1 (set wins).
//    clr_flag_A one cycle later -> flag_A=0, irq_n=1.
//  5 load_A dropped for 50 samples mid-count -> cnt_A frozen.
//    Re-raised -> reloads value_A; period is measured from the re-raise.
//  6 clk_en every 3rd cycle -> tick spacing 72 clk; with TIMER_CSM_EN and csm_mode=1 -> csm_keyon high for 24 clk_en.

Source files
------------

// File: rtl/jt12_timers_ab.sv
// FM timer A/B: sample tick from clk_en, two reloading up-counters, sticky flags, registered IRQ.
// Optional TIMER_CSM_EN macro adds csm_mode/csm_keyon (CSM key-on pulse on timer A overflow).
module jt12_timers_ab #(
    parameter int SLOTS = 24,
    parameter int B_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic [9:0] value_A,
    input  logic [7:0] value_B,
    input  logic       load_A,
    input  logic       load_B,
    input  logic       flagen_A,
    input  logic       flagen_B,
    input  logic       clr_flag_A,
    input  logic       clr_flag_B,
`ifdef TIMER_CSM_EN
    input  logic       csm_mode,
    output logic       csm_keyon,
`endif
    output logic       flag_A,
    output logic       flag_B,
    output logic       overflow_A,
    output logic       irq_n
);

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
    localparam logic [3:0] BDIV_LAST = 4'(B_DIV - 1);

    logic [4:0] slot_cnt_q, slot_cnt_d;
    logic [3:0] bdiv_cnt_q, bdiv_cnt_d;
    logic [9:0] cnt_A_q, cnt_A_d;
    logic [7:0] cnt_B_q, cnt_B_d;
    logic       load_A_q, load_B_q;
    logic       overflow_A_q, overflow_A_d;
    logic       overflow_B_q, overflow_B_d;
    logic       flag_A_q, flag_A_d;
    logic       flag_B_q, flag_B_d;
    logic       irq_n_q, irq_n_d;
    logic       tick, btick, rise_A, rise_B, wrap_A, wrap_B;

    always_comb begin
        tick   = clk_en && (slot_cnt_q == SLOT_LAST);
        btick  = tick && (bdiv_cnt_q == BDIV_LAST);
        rise_A = load_A && !load_A_q;
        rise_B = load_B && !load_B_q;
        wrap_A = tick && load_A && (cnt_A_q == 10'h3FF);
        wrap_B = btick && load_B && (cnt_B_q == 8'hFF);

        slot_cnt_d = slot_cnt_q;
        if (clk_en)
            slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? 5'd0 : slot_cnt_q + 5'd1;

        bdiv_cnt_d = bdiv_cnt_q;
        if (tick)
            bdiv_cnt_d = (bdiv_cnt_q == BDIV_LAST) ? 4'd0 : bdiv_cnt_q + 4'd1;

        // A fresh load edge wins over counting; the overflow strobe is still produced.
        cnt_A_d = cnt_A_q;
        if (rise_A)
            cnt_A_d = value_A;
        else if (tick && load_A)
            cnt_A_d = wrap_A ? value_A : cnt_A_q + 10'd1;

        cnt_B_d = cnt_B_q;
        if (rise_B)
            cnt_B_d = value_B;
        else if (btick && load_B)
            cnt_B_d = wrap_B ? value_B : cnt_B_q + 8'd1;

        overflow_A_d = wrap_A;
        overflow_B_d = wrap_B;

        flag_A_d = flag_A_q;
        if (overflow_A_q && flagen_A)
            flag_A_d = 1'b1;
        else if (clr_flag_A)
            flag_A_d = 1'b0;

        flag_B_d = flag_B_q;
        if (overflow_B_q && flagen_B)
            flag_B_d = 1'b1;
        else if (clr_flag_B)
            flag_B_d = 1'b0;

        // Built from next-state flags so irq_n changes on the same edge as the flags.
        irq_n_d = !(flag_A_d || flag_B_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= 5'd0;
            bdiv_cnt_q   <= 4'd0;
            cnt_A_q      <= 10'd0;
            cnt_B_q      <= 8'd0;
            load_A_q     <= 1'b0;
            load_B_q     <= 1'b0;
            overflow_A_q <= 1'b0;
            overflow_B_q <= 1'b0;
            flag_A_q     <= 1'b0;
            flag_B_q     <= 1'b0;
            irq_n_q      <= 1'b1;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            bdiv_cnt_q   <= bdiv_cnt_d;
            cnt_A_q      <= cnt_A_d;
            cnt_B_q      <= cnt_B_d;
            load_A_q     <= load_A;
            load_B_q     <= load_B;
            overflow_A_q <= overflow_A_d;
            overflow_B_q <= overflow_B_d;
            flag_A_q     <= flag_A_d;
            flag_B_q     <= flag_B_d;
            irq_n_q      <= irq_n_d;
        end
    end

    assign flag_A     = flag_A_q;
    assign flag_B     = flag_B_q;
    assign overflow_A = overflow_A_q;
    assign irq_n      = irq_n_q;

`ifdef TIMER_CSM_EN
    logic [4:0] csm_cnt_q, csm_cnt_d;

    // Key-on length counts clk_en periods; a retrigger reloads the full length.
    always_comb begin
        csm_cnt_d = csm_cnt_q;
        if (wrap_A && csm_mode)
            csm_cnt_d = 5'(SLOTS);
        else if (clk_en && (csm_cnt_q != 5'd0))
            csm_cnt_d = csm_cnt_q - 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csm_cnt_q <= 5'd0;
        else
            csm_cnt_q <= csm_cnt_d;
    end

    assign csm_keyon = (csm_cnt_q != 5'd0);
`endif

endmodule

// File: tb/tb_jt12_timers_ab.sv
// Directed bench for jt12_timers_ab (SLOTS=24, B_DIV=16); edges counted from reset release.
module tb_jt12_timers_ab;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B;
    logic       flag_A, flag_B, overflow_A, irq_n;
`ifdef TIMER_CSM_EN
    logic       csm_mode;
    logic       csm_keyon;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    jt12_timers_ab #(.SLOTS(24), .B_DIV(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .value_A    (value_A),
        .value_B    (value_B),
        .load_A     (load_A),
        .load_B     (load_B),
        .flagen_A   (flagen_A),
        .flagen_B   (flagen_B),
        .clr_flag_A (clr_flag_A),
        .clr_flag_B (clr_flag_B),
`ifdef TIMER_CSM_EN
        .csm_mode   (csm_mode),
        .csm_keyon  (csm_keyon),
`endif
        .flag_A     (flag_A),
        .flag_B     (flag_B),
        .overflow_A (overflow_A),
        .irq_n      (irq_n)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        clk_en = 0; value_A = 0; value_B = 0; load_A = 0; load_B = 0;
        flagen_A = 0; flagen_B = 0; clr_flag_A = 0; clr_flag_B = 0;
`ifdef TIMER_CSM_EN
        csm_mode = 0;
`endif
    endtask

    // Leaves time at #1 after edge E0; inputs set now are first sampled at E1.
    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        cyc(2);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        value_A = 10'd1023; load_A = 1; flagen_A = 1; clk_en = 1;
        cyc(30);
        n_checks++;
        if (flag_A !== 1'b1) $display("FAIL pre_reset_flag_A got=%b exp=1", flag_A); else n_pass++;
        rst_n = 0;
        #1;
        n_checks++;
        if (flag_A !== 1'b0) $display("FAIL reset_flag_A got=%b exp=0", flag_A); else n_pass++;
        n_checks++;
        if (flag_B !== 1'b0) $display("FAIL reset_flag_B got=%b exp=0", flag_B); else n_pass++;
        n_checks++;
        if (overflow_A !== 1'b0) $display("FAIL reset_overflow_A got=%b exp=0", overflow_A); else n_pass++;
        n_checks++;
        if (irq_n !== 1'b1) $display("FAIL reset_irq_n got=%b exp=1", irq_n); else n_pass++;
        flagen_A = 0;
        cyc(2);
        rst_n = 1;
        cyc(23);
        n_checks++;
        if (overflow_A !== 1'b0) $display("FAIL first_tick_early got=%b exp=0", overflow_A); else n_pass++;
        cyc(1);
        n_checks++;
        if (overflow_A !== 1'b1) $display("FAIL first_tick_e24 got=%b exp=1", overflow_A); else n_pass++;
    endtask

    task automatic test_timer_a();
        do_reset();
        value_A = 10'd1020; flagen_A = 1; clk_en = 1; load_A = 1;
        cyc(95);
        n_checks++;
        if (overflow_A !== 1'b0) $display("FAIL a_ovf_e95 got=%b exp=0", overflow_A); else n_pass++;
        cyc(1);
        n_checks++;
        if (overflow_A !== 1'b1) $display("FAIL a_ovf_e96 got=%b exp=1", overflow_A); else n_pass++;
        n_checks++;
        if (flag_A !== 1'b0) $display("FAIL a_flag_e96 got=%b exp=0", flag_A); else n_pass++;
        n_checks++;
        if (irq_n !== 1'b1) $display("FAIL a_irq_e96 got=%b exp=1", irq_n); else n_pass++;
        cyc(1);
        n_checks++;
        if (overflow_A !== 1'b0) $display("FAIL a_ovf_e97 got=%b exp=0", overflow_A); else n_pass++;
        n_checks++;
        if (flag_A !== 1'b1) $display("FAIL a_flag_e97 got=%b exp=1", flag_A); else n_pass++;
        n_checks++;
        if (irq_n !== 1'b0) $display("FAIL a_irq_e97 got=%b exp=0", irq_n); else n_pass++;
        cyc(95);
        n_checks++;
        if (overflow_A !== 1'b1) $display("FAIL a_ovf_e192 got=%b exp=1", overflow_A); else n_pass++;
    endtask

    task automatic test_timer_b();
        do_reset();
        value_B = 8'd254; load_B = 1; flagen_B = 0; clk_en = 1;
        cyc(800);
        n_checks++;
        if (flag_B !== 1'b0) $display("FAIL b_noflag got=%b exp=0", flag_B); else n_pass++;
        n_checks++;
        if (irq_n !== 1'b1) $display("FAIL b_noflag_irq got=%b exp=1", irq_n); else n_pass++;
        flagen_B = 1;
        cyc(736);
        n_checks++;
        if (flag_B !== 1'b0) $display("FAIL b_flag_e1536 got=%b exp=0", flag_B); else n_pass++;
        cyc(1);
        n_checks++;
        if (flag_B !== 1'b1) $display("FAIL b_flag_e1537 got=%b exp=1", flag_B); else n_pass++;
        n_checks++;
        if (irq_n !== 1'b0) $display("FAIL b_irq_e1537 got=%b exp=0", irq_n); else n_pass++;
    endtask

    task automatic test_clr_set();
        do_reset();
        value_A = 10'd1023; load_A = 1; flagen_A = 1; clk_en = 1;
        cyc(48);
        n_checks++;
        if (overflow_A !== 1'b1) $display("FAIL clr_ovf_e48 got=%b exp=1", overflow_A); else n_pass++;
        clr_flag_A = 1;
        cyc(1);
        n_checks++;
        if (flag_A !== 1'b1) $display("FAIL clr_set_wins got=%b exp=1", flag_A); else n_pass++;
        cyc(1);
        clr_flag_A = 0;
        n_checks++;
        if (flag_A !== 1'b0) $display("FAIL clr_flag_A got=%b exp=0", flag_A); else n_pass++;
        n_checks++;
        if (irq_n !== 1'b1) $display("FAIL clr_irq_n got=%b exp=1", irq_n); else n_pass++;
    endtask

    task automatic test_hold();
        int n_ovf;
        do_reset();
        value_A = 10'd1000; load_A = 1; flagen_A = 1; clk_en = 1;
        cyc(240);
        load_A = 0;
        n_ovf = 0;
        for (int i = 0; i < 1200; i++) begin
            cyc(1);
            if (overflow_A === 1'b1) n_ovf++;
        end
        n_checks++;
        if (n_ovf !== 0) $display("FAIL hold_no_ovf got=%0d exp=0", n_ovf); else n_pass++;
        n_checks++;
        if (flag_A !== 1'b0) $display("FAIL hold_flag got=%b exp=0", flag_A); else n_pass++;
        load_A = 1;
        cyc(575);
        n_checks++;
        if (overflow_A !== 1'b0) $display("FAIL hold_reload_early got=%b exp=0", overflow_A); else n_pass++;
        cyc(1);
        n_checks++;
        if (overflow_A !== 1'b1) $display("FAIL hold_reload_period got=%b exp=1", overflow_A); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        value_A = 10'd1023; load_A = 1; flagen_A = 1; clk_en = 1;
        cyc(30);
        load_A = 0; clr_flag_A = 1;
        cyc(1);
        clr_flag_A = 0;
        cyc(16);
        value_A = 10'd1020; load_A = 1;
        cyc(1);
        n_checks++;
        if (overflow_A !== 1'b1) $display("FAIL simul_ovf got=%b exp=1", overflow_A); else n_pass++;
        cyc(1);
        n_checks++;
        if (flag_A !== 1'b1) $display("FAIL simul_flag got=%b exp=1", flag_A); else n_pass++;
        cyc(71);
        n_checks++;
        if (overflow_A !== 1'b0) $display("FAIL simul_e120 got=%b exp=0", overflow_A); else n_pass++;
        cyc(24);
        n_checks++;
        if (overflow_A !== 1'b1) $display("FAIL simul_e144 got=%b exp=1", overflow_A); else n_pass++;
    endtask

    task automatic test_clk_en_gap();
        int n_ovf, first_ovf, second_ovf, n_kon;
        do_reset();
        value_A = 10'd1022; load_A = 1; clk_en = 0;
`ifdef TIMER_CSM_EN
        csm_mode = 1;
`endif
        n_ovf = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (overflow_A === 1'b1) n_ovf++;
        end
        n_checks++;
        if (n_ovf !== 0) $display("FAIL no_clk_en_ovf got=%0d exp=0", n_ovf); else n_pass++;
        first_ovf = -1; second_ovf = -1; n_kon = 0;
        for (int i = 0; i < 300; i++) begin
            clk_en = (i % 3 == 0);
            cyc(1);
            if (overflow_A === 1'b1) begin
                if (first_ovf < 0) first_ovf = i + 1;
                else if (second_ovf < 0) second_ovf = i + 1;
            end
`ifdef TIMER_CSM_EN
            if (csm_keyon === 1'b1 && (i + 1) >= 142 && (i + 1) < 286) n_kon++;
`endif
        end
        clk_en = 0;
        n_checks++;
        if (first_ovf !== 142) $display("FAIL gap_first_ovf got=%0d exp=142", first_ovf); else n_pass++;
        n_checks++;
        if (second_ovf !== 286) $display("FAIL gap_second_ovf got=%0d exp=286", second_ovf); else n_pass++;
`ifdef TIMER_CSM_EN
        n_checks++;
        if (n_kon !== 72) $display("FAIL csm_keyon_len got=%0d exp=72", n_kon); else n_pass++;
`endif
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_timer_a();
        test_timer_b();
        test_clr_set();
        test_hold();
        test_back_to_back();
        test_clk_en_gap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
